dht22_sensor_model: RTL and testbench
=====================================

Name: dht22_sensor_model

Overview:
- Synthesizable responder (sensor side) of the DHT22 single-wire protocol.
- Detects a host start pulse on the open-drain bus, then sends the ack sequence and a 40-bit frame: humidity[15:0], temperature[15:0], checksum[7:0].
- Used as an on-FPGA stand-in sensor and as the bus partner for verifying the DHT22 host block.

Parameters:
- CLK_HZ, 1_000_000: clk frequency. Must be an integer multiple of 1_000_000.
- START_MIN_US, 500: minimum host low time accepted as a start.
- ACK_DELAY_US, 30: delay from host release to ack low.
- ACK_LOW_US, 80: ack low phase.
- ACK_HIGH_US, 80: ack high (released) phase.
- BIT_LOW_US, 50: low lead-in before each bit and the trailing end low.
- BIT0_HIGH_US, 26: released time for a 0 bit.
- BIT1_HIGH_US, 70: released time for a 1 bit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dht_pin  inout  1  open-drain bus; block drives 0 or releases (z), never drives 1
- humidity  in  16  humidity word to report (x10 %RH)
- temperature  in  16  temperature word to report (bit15 = sign, magnitude x10 degC)
- busy  out  1  high from start acceptance until frame end
- frame_done  out  1  one-cycle pulse after end low completes
- short_start  out  1  one-cycle pulse when a host low is shorter than START_MIN_US

Behaviour:
- Reset: dht_pin released, busy=0, frame_done=0, short_start=0, state IDLE, armed=0. Reset asserted mid-frame releases the pin asynchronously.
- Pin input passes through a 2-flop synchronizer. Edge detection uses the synced value, so detection latency is 2 cycles.
- Microsecond prescaler: 1 us tick every CLK_HZ/1e6 cycles. The prescaler and us counter restart on every state entry, so each driven phase lasts exactly N*CLK_HZ/1e6 cycles.
- IDLE: pin released. armed is set once synced pin = 1; a low at reset release is ignored until the bus goes high. armed and falling edge -> HOST_LOW.
- HOST_LOW: count us while low; counter saturates at 2^16-1. On rising edge:
  - count >= START_MIN_US -> ACK_WAIT, busy=1, snapshot humidity and temperature into the shift register.
  - otherwise pulse short_start -> IDLE.
- ACK_WAIT: released for ACK_DELAY_US -> ACK_LOW.
- ACK_LOW: drive 0 for ACK_LOW_US -> ACK_HIGH.
- ACK_HIGH: release for ACK_HIGH_US -> BIT_LOW.
- BIT_LOW: drive 0 for BIT_LOW_US -> BIT_HIGH.
- BIT_HIGH: release for BIT1_HIGH_US if current bit = 1, else BIT0_HIGH_US. Then:
  - bit index < 39 -> BIT_LOW (next bit).
  - bit index = 39 -> END_LOW.
- END_LOW: drive 0 for BIT_LOW_US, release, pulse frame_done, busy=0 -> IDLE.
- Frame bit order is MSB first: humidity[15:8], humidity[7:0], temperature[15:8], temperature[7:0], checksum.
- Checksum = (sum of the four data bytes) mod 256, computed from the snapshot. Input changes during busy do not affect the frame in flight.
- Bus activity by the host during busy is ignored; no restart detection while busy.
- Bit counter is 6 bits and resets to 0 on entry to ACK_WAIT.

Optional Feature:
- Macro DHT22_FAULT_INJECT_EN.
- Defined: adds input port fault_crc (1 bit), sampled at snapshot. If 1, the transmitted checksum is bitwise inverted; data bytes are unchanged.
- Undefined: no fault_crc port; checksum is always correct.

Test Plan:
- CLK_HZ=1e6, humidity=0x028C, temperature=0x015F; host low 1000 us then release -> ack low at +30 us lasting 80 us, high 80 us, 40 bits decoding 0x028C, 0x015F, checksum 0xEE; then end low 50 us, frame_done pulse, busy falls.
- Host low 100 us -> short_start pulse, no pin drive, busy stays 0.
- temperature=0x8065, humidity=0x0000 -> bytes 80 65 00 00 (as transmitted: 00 00 80 65), checksum 0xE5; first temperature bit high time 70 us.
- humidity changed to 0x1234 during bit 10 -> current frame still sends 0x028C; next frame sends 0x1234.
- rst asserted during ACK_LOW -> pin released in the same cycle, busy=0; a valid start after reset gives a normal full frame.
- DHT22_FAULT_INJECT_EN defined, fault_crc=1, data as in the first scenario -> checksum byte transmitted as 0x11.

Source files
------------

// File: rtl/dht22_sensor_model.sv
// dht22_sensor_model: sensor-side responder for the DHT22 single-wire bus.
// Waits for a host start pulse, then answers with the ack sequence and a
// 40-bit frame {humidity, temperature, checksum}, MSB first.
// Optional feature macro: DHT22_FAULT_INJECT_EN adds the fault_crc input,
// which inverts the transmitted checksum when set at snapshot time.
module dht22_sensor_model #(
  parameter int unsigned CLK_HZ       = 1_000_000,
  parameter int unsigned START_MIN_US = 500,
  parameter int unsigned ACK_DELAY_US = 30,
  parameter int unsigned ACK_LOW_US   = 80,
  parameter int unsigned ACK_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned BIT0_HIGH_US = 26,
  parameter int unsigned BIT1_HIGH_US = 70
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         dht_pin,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
`ifdef DHT22_FAULT_INJECT_EN
  input  logic        fault_crc,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic        short_start
);

  localparam int unsigned DIV      = CLK_HZ / 1_000_000;
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned UW       = 16;
  localparam int unsigned FW       = 40;
  localparam int unsigned LAST_BIT = FW - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_ACK_WAIT,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            prev;
  logic            armed;
  logic            pin_low;
  logic [PW-1:0]   presc;
  logic [UW-1:0]   us_cnt;
  logic [FW-1:0]   shreg;
  logic [5:0]      bit_idx;

  logic            tick_c;
  logic            fall_c;
  logic            rise_c;
  logic            phase_done_c;
  logic [UW-1:0]   target_c;
  logic [7:0]      csum_c;

  // Open-drain output: only ever pull low or release.
  assign dht_pin = pin_low ? 1'b0 : 1'bz;

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= dht_pin;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall_c = prev & ~sync2;
  assign rise_c = ~prev & sync2;
  assign tick_c = (presc == PW'(DIV - 1));

  // Checksum over the four data bytes, optionally corrupted for fault tests.
  always_comb begin
    csum_c = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
`ifdef DHT22_FAULT_INJECT_EN
    csum_c = csum_c ^ {8{fault_crc}};
`endif
  end

  // Length in microseconds of the timed phase belonging to the current state.
  always_comb begin
    target_c = UW'(1);
    case (state)
      S_ACK_WAIT: target_c = UW'(ACK_DELAY_US);
      S_ACK_LOW:  target_c = UW'(ACK_LOW_US);
      S_ACK_HIGH: target_c = UW'(ACK_HIGH_US);
      S_BIT_LOW:  target_c = UW'(BIT_LOW_US);
      S_BIT_HIGH: target_c = shreg[LAST_BIT] ? UW'(BIT1_HIGH_US) : UW'(BIT0_HIGH_US);
      S_END_LOW:  target_c = UW'(BIT_LOW_US);
      default:    target_c = UW'(1);
    endcase
  end

  assign phase_done_c = tick_c && (us_cnt == (target_c - UW'(1)));

  // Protocol state machine; prescaler and us counter restart on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      pin_low     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_start <= 1'b0;
      presc       <= '0;
      us_cnt      <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
    end else begin
      frame_done  <= 1'b0;
      short_start <= 1'b0;
      presc       <= tick_c ? '0 : presc + PW'(1);
      if (tick_c && (us_cnt != '1)) begin
        us_cnt <= us_cnt + UW'(1);
      end

      case (state)
        S_IDLE: begin
          pin_low <= 1'b0;
          if (sync2) begin
            armed <= 1'b1;
          end
          if (armed && fall_c) begin
            state  <= S_HOST_LOW;
            presc  <= '0;
            us_cnt <= '0;
          end
        end

        S_HOST_LOW: begin
          if (rise_c) begin
            presc  <= '0;
            us_cnt <= '0;
            if (us_cnt >= UW'(START_MIN_US)) begin
              state   <= S_ACK_WAIT;
              busy    <= 1'b1;
              shreg   <= {humidity, temperature, csum_c};
              bit_idx <= '0;
            end else begin
              state       <= S_IDLE;
              short_start <= 1'b1;
            end
          end
        end

        S_ACK_WAIT: begin
          if (phase_done_c) begin
            state   <= S_ACK_LOW;
            pin_low <= 1'b1;
            presc   <= '0;
            us_cnt  <= '0;
          end
        end

        S_ACK_LOW: begin
          if (phase_done_c) begin
            state   <= S_ACK_HIGH;
            pin_low <= 1'b0;
            presc   <= '0;
            us_cnt  <= '0;
          end
        end

        S_ACK_HIGH: begin
          if (phase_done_c) begin
            state   <= S_BIT_LOW;
            pin_low <= 1'b1;
            presc   <= '0;
            us_cnt  <= '0;
          end
        end

        S_BIT_LOW: begin
          if (phase_done_c) begin
            state   <= S_BIT_HIGH;
            pin_low <= 1'b0;
            presc   <= '0;
            us_cnt  <= '0;
          end
        end

        S_BIT_HIGH: begin
          if (phase_done_c) begin
            shreg   <= {shreg[LAST_BIT-1:0], 1'b0};
            pin_low <= 1'b1;
            presc   <= '0;
            us_cnt  <= '0;
            if (bit_idx == 6'(LAST_BIT)) begin
              state <= S_END_LOW;
            end else begin
              state   <= S_BIT_LOW;
              bit_idx <= bit_idx + 6'd1;
            end
          end
        end

        S_END_LOW: begin
          if (phase_done_c) begin
            state      <= S_IDLE;
            pin_low    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            presc      <= '0;
            us_cnt     <= '0;
          end
        end

        default: begin
          state   <= S_IDLE;
          pin_low <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_sensor_model.sv
// tb_dht22_sensor_model: drives host start pulses on the open-drain bus,
// times every bus phase of the reply and decodes the frame, comparing it
// with a frame/timing model built from the protocol rules.
module tb_dht22_sensor_model;

  localparam int unsigned CLK_HZ       = 1_000_000;
  localparam int unsigned START_MIN_US = 500;
  localparam int unsigned ACK_DELAY_US = 30;
  localparam int unsigned ACK_LOW_US   = 80;
  localparam int unsigned ACK_HIGH_US  = 80;
  localparam int unsigned BIT_LOW_US   = 50;
  localparam int unsigned BIT0_HIGH_US = 26;
  localparam int unsigned BIT1_HIGH_US = 70;
  localparam int unsigned CYC          = CLK_HZ / 1_000_000;
  localparam int          ACK_MIN      = int'(ACK_DELAY_US * CYC);
  localparam int          ACK_MAX      = ACK_MIN + 4;
  localparam int          NRUNS        = 84;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_low;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        fault_crc;
  logic        busy;
  logic        frame_done;
  logic        short_start;
  wire         dht_pin;

  assign dht_pin = host_low ? 1'b0 : 1'bz;
  pullup pu_bus (dht_pin);

  dht22_sensor_model #(
    .CLK_HZ(CLK_HZ), .START_MIN_US(START_MIN_US), .ACK_DELAY_US(ACK_DELAY_US),
    .ACK_LOW_US(ACK_LOW_US), .ACK_HIGH_US(ACK_HIGH_US), .BIT_LOW_US(BIT_LOW_US),
    .BIT0_HIGH_US(BIT0_HIGH_US), .BIT1_HIGH_US(BIT1_HIGH_US)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dht_pin(dht_pin),
    .humidity(humidity),
    .temperature(temperature),
`ifdef DHT22_FAULT_INJECT_EN
    .fault_crc(fault_crc),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .short_start(short_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Measurements from the most recent captured frame.
  int   run_len[$];
  logic cap_timeout;
  int   busy_gaps;
  logic fd_after;

  // Reference frame: data words followed by the byte-sum checksum.
  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t,
                                              input logic flt);
    int sum;
    logic [7:0] cs;
    sum = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    cs  = 8'(sum % 256);
    if (flt) cs = ~cs;
    return {h, t, cs};
  endfunction

  // Count bus phases whose measured length differs from the protocol timing for frame f.
  function automatic int width_errors(input logic [39:0] f);
    int e;
    if (run_len.size() != NRUNS) return 999;
    e = 0;
    if (run_len[1] != int'(ACK_LOW_US * CYC)) e++;
    if (run_len[2] != int'(ACK_HIGH_US * CYC)) e++;
    for (int i = 0; i < 40; i++) begin
      if (run_len[3 + 2 * i] != int'(BIT_LOW_US * CYC)) e++;
      if (run_len[4 + 2 * i] != int'((f[39 - i] ? BIT1_HIGH_US : BIT0_HIGH_US) * CYC)) e++;
    end
    if (run_len[83] != int'(BIT_LOW_US * CYC)) e++;
    return e;
  endfunction

  // Bit value from high-phase length: longer than the midpoint means 1.
  function automatic logic [39:0] decode();
    logic [39:0] d;
    if (run_len.size() != NRUNS) return 'x;
    for (int i = 0; i < 40; i++)
      d[39 - i] = (run_len[4 + 2 * i] > int'((BIT0_HIGH_US + BIT1_HIGH_US) * CYC / 2));
    return d;
  endfunction

  function automatic int ack_delay();
    return (run_len.size() > 0) ? run_len[0] : -1;
  endfunction

  task automatic host_pulse(input int unsigned low_us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_us * CYC) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  // Record run lengths of the bus level after host release until frame_done.
  task automatic capture(input int chg_bit, input logic [15:0] chg_hum);
    logic cur;
    logic lvl;
    int   len;
    run_len.delete();
    cap_timeout = 1'b1;
    busy_gaps   = 0;
    cur = 1'b1;
    len = 0;
    for (int c = 0; c < int'(7000 * CYC); c++) begin
      @(negedge clk);
      lvl = (dht_pin !== 1'b0);
      if (lvl == cur) len++;
      else begin
        run_len.push_back(len);
        cur = lvl;
        len = 1;
      end
      if (frame_done === 1'b1) begin
        cap_timeout = 1'b0;
        break;
      end
      if (run_len.size() >= 1 && busy !== 1'b1) busy_gaps++;
      if (chg_bit >= 0 && run_len.size() == 4 + 2 * chg_bit) humidity = chg_hum;
    end
    @(negedge clk);
    fd_after = frame_done;
  endtask

  // Observe the idle bus for n cycles after a host pulse.
  task automatic watch_idle(input int n, output int ss, output int lows, output int busys);
    ss = 0; lows = 0; busys = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (short_start === 1'b1) ss++;
      if (dht_pin === 1'b0) lows++;
      if (busy !== 1'b0) busys++;
    end
  endtask

  task automatic test_reset();
    int ss, lows, busys;
    rst = 1'b1;
    host_low = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, short_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: busy/frame_done/short_start=%b, required 000",
               {busy, frame_done, short_start});
    end
    rst = 1'b0;
    // Bus held low through reset release must not count as a start.
    repeat (600) @(negedge clk);
    host_low = 1'b0;
    watch_idle(100, ss, lows, busys);
    checks++;
    if (ss != 0 || busys != 0 || lows != 0) begin
      errors++;
      $display("FAIL reset_low_ignored: short_start=%0d busy=%0d dut_low=%0d, required 0 0 0",
               ss, busys, lows);
    end
    checks++;
    if (dht_pin !== 1'b1) begin
      errors++;
      $display("FAIL reset_pin_released: pin=%b, required 1", dht_pin);
    end
  endtask

  task automatic test_basic_frame();
    logic [39:0] exp;
    logic [39:0] got;
    humidity = 16'h028C;
    temperature = 16'h015F;
    exp = model_frame(humidity, temperature, 1'b0);
    host_pulse(1000);
    capture(-1, 16'h0);
    got = decode();
    checks++;
    if (cap_timeout) begin
      errors++;
      $display("FAIL basic_timeout: no frame_done within cycle budget");
    end
    checks++;
    if (ack_delay() < ACK_MIN || ack_delay() > ACK_MAX) begin
      errors++;
      $display("FAIL basic_ack_delay: %0d cycles, required %0d..%0d", ack_delay(), ACK_MIN, ACK_MAX);
    end
    checks++;
    if (width_errors(exp) != 0) begin
      errors++;
      $display("FAIL basic_widths: %0d phase length errors (runs=%0d), required 0",
               width_errors(exp), run_len.size());
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL basic_frame: got %h, required %h", got, exp);
    end
    checks++;
    if (got[7:0] !== 8'hEE) begin
      errors++;
      $display("FAIL basic_checksum: got %h, required ee", got[7:0]);
    end
    checks++;
    if (busy_gaps != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: gaps=%0d end_busy=%b, required 0 0", busy_gaps, busy);
    end
    checks++;
    if (fd_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame_done_width: second cycle frame_done=%b, required 0", fd_after);
    end
    settle();
  endtask

  task automatic test_start_threshold();
    int ss, lows, busys;
    logic [39:0] exp;
    host_pulse(100);
    watch_idle(200, ss, lows, busys);
    checks++;
    if (ss != 1 || lows != 0 || busys != 0) begin
      errors++;
      $display("FAIL short_100us: short_start=%0d dut_low=%0d busy=%0d, required 1 0 0", ss, lows, busys);
    end
    host_pulse(START_MIN_US - 20);
    watch_idle(200, ss, lows, busys);
    checks++;
    if (ss != 1 || lows != 0 || busys != 0) begin
      errors++;
      $display("FAIL short_below_min: short_start=%0d dut_low=%0d busy=%0d, required 1 0 0", ss, lows, busys);
    end
    humidity = 16'h55AA;
    temperature = 16'h0F0F;
    exp = model_frame(humidity, temperature, 1'b0);
    host_pulse(START_MIN_US + 20);
    capture(-1, 16'h0);
    checks++;
    if (cap_timeout || decode() !== exp) begin
      errors++;
      $display("FAIL start_above_min: got %h timeout=%b, required %h", decode(), cap_timeout, exp);
    end
    settle();
  endtask

  task automatic test_sign_temp();
    logic [39:0] exp;
    logic [39:0] got;
    humidity = 16'h0000;
    temperature = 16'h8065;
    exp = model_frame(humidity, temperature, 1'b0);
    host_pulse(800);
    capture(-1, 16'h0);
    got = decode();
    checks++;
    if (got !== exp || got[7:0] !== 8'hE5) begin
      errors++;
      $display("FAIL sign_frame: got %h, required %h (checksum e5)", got, exp);
    end
    checks++;
    if (run_len.size() != NRUNS || run_len[4 + 2 * 16] != int'(BIT1_HIGH_US * CYC)) begin
      errors++;
      $display("FAIL sign_bit_high: runs=%0d width=%0d, required %0d",
               run_len.size(), (run_len.size() == NRUNS) ? run_len[36] : -1, BIT1_HIGH_US * CYC);
    end
    settle();
  endtask

  task automatic test_input_change();
    logic [39:0] got;
    humidity = 16'h028C;
    temperature = 16'h015F;
    host_pulse(700);
    capture(10, 16'h1234);
    got = decode();
    checks++;
    if (humidity !== 16'h1234 || got !== model_frame(16'h028C, 16'h015F, 1'b0)) begin
      errors++;
      $display("FAIL change_in_flight: got %h, required %h", got, model_frame(16'h028C, 16'h015F, 1'b0));
    end
    settle();
    host_pulse(700);
    capture(-1, 16'h0);
    got = decode();
    checks++;
    if (got !== model_frame(16'h1234, 16'h015F, 1'b0)) begin
      errors++;
      $display("FAIL change_next_frame: got %h, required %h", got, model_frame(16'h1234, 16'h015F, 1'b0));
    end
    settle();
  endtask

  task automatic test_reset_mid();
    logic found;
    logic [39:0] exp;
    humidity = 16'h0ABC;
    temperature = 16'h0123;
    host_pulse(1000);
    found = 1'b0;
    for (int c = 0; c < int'(100 * CYC); c++) begin
      @(negedge clk);
      if (dht_pin === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_ack_seen: no ack low within budget");
    end
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dht_pin !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: pin=%b busy=%b, required 1 0", dht_pin, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    settle();
    exp = model_frame(humidity, temperature, 1'b0);
    host_pulse(900);
    capture(-1, 16'h0);
    checks++;
    if (cap_timeout || decode() !== exp || width_errors(exp) != 0) begin
      errors++;
      $display("FAIL midreset_recover: got %h werr=%0d, required %h werr=0", decode(), width_errors(exp), exp);
    end
    settle();
  endtask

  task automatic test_random();
    logic [39:0] exp;
    int ss, lows, busys;
    int unsigned low;
    for (int n = 0; n < 4; n++) begin
      humidity = 16'($urandom);
      temperature = 16'($urandom);
      exp = model_frame(humidity, temperature, 1'b0);
      host_pulse($urandom_range(900, START_MIN_US + 20));
      capture(-1, 16'h0);
      checks++;
      if (cap_timeout || decode() !== exp || width_errors(exp) != 0 ||
          ack_delay() < ACK_MIN || ack_delay() > ACK_MAX) begin
        errors++;
        $display("FAIL random_frame_%0d: got %h werr=%0d ack=%0d, required %h werr=0 ack=%0d..%0d",
                 n, decode(), width_errors(exp), ack_delay(), exp, ACK_MIN, ACK_MAX);
      end
      settle();
      low = $urandom_range(START_MIN_US - 20, 40);
      host_pulse(low);
      watch_idle(50, ss, lows, busys);
      checks++;
      if (ss != 1 || lows != 0 || busys != 0) begin
        errors++;
        $display("FAIL random_short_%0d: low=%0d short_start=%0d dut_low=%0d busy=%0d, required 1 0 0",
                 n, low, ss, lows, busys);
      end
    end
  endtask

`ifdef DHT22_FAULT_INJECT_EN
  task automatic test_fault_crc();
    logic [39:0] got;
    humidity = 16'h028C;
    temperature = 16'h015F;
    fault_crc = 1'b1;
    host_pulse(1000);
    fault_crc = 1'b0;
    capture(-1, 16'h0);
    got = decode();
    checks++;
    if (got !== model_frame(16'h028C, 16'h015F, 1'b1) || got[7:0] !== 8'h11) begin
      errors++;
      $display("FAIL fault_crc: got %h, required %h", got, model_frame(16'h028C, 16'h015F, 1'b1));
    end
    settle();
  endtask
`endif

  initial begin
    repeat (200_000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    host_low = 1'b0;
    humidity = 16'h0;
    temperature = 16'h0;
    fault_crc = 1'b0;
    test_reset();
    test_basic_frame();
    test_start_threshold();
    test_sign_temp();
    test_input_change();
    test_reset_mid();
    test_random();
`ifdef DHT22_FAULT_INJECT_EN
    test_fault_crc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
